ctrl_mc: RTL

Multi-cycle SISC control FSM, second generation. Sequences fetch/decode/execute/mem/writeback per instruction and drives register-file, ALU, PC, IR and data-memory control. Adds to the first-generation controller a memory-ready handshake with bounded wait states, and a branch-condition evaluation. It also adds a two-cycle SWP writeback and a clean HALT state with sticky error flags, replacing $stop. Sits between the IR/status register and the datapath.

---
 rtl/ctrl_mc.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ctrl_mc.sv
// Multi-cycle SISC control FSM: fetch/decode/execute/mem/writeback sequencing with a
// bounded memory-ready handshake, branch evaluation, two-cycle SWP writeback and HALT.
module ctrl_mc #(
    parameter int OPW      = 4,
    parameter int MMW      = 4,
    parameter int ALUW     = 2,
    parameter int WAIT_MAX = 15,
    parameter int AM_IMM   = 8
) (
    input  logic            clk,
    input  logic            rst_f,
    input  logic [OPW-1:0]  opcode,
    input  logic [MMW-1:0]  mm,
    input  logic [MMW-1:0]  stat,
    input  logic            mem_rdy,
    output logic            rf_we,
    output logic [ALUW-1:0] alu_op,
    output logic            wb_sel,
    output logic            rb_sel,
    output logic            ir_load,
    output logic            pc_write,
    output logic            pc_sel,
    output logic            br_sel,
    output logic            mem_req,
    output logic            mem_we,
    output logic            halted,
    output logic            bus_err,
    output logic            ill_op,
    output logic [2:0]      state_o
);

    typedef enum logic [2:0] {
        START1  = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        WB2     = 3'd6,
        HALT    = 3'd7
    } state_t;

    localparam logic [OPW-1:0] OP_NOOP = OPW'(0);
    localparam logic [OPW-1:0] OP_LOD  = OPW'(1);
    localparam logic [OPW-1:0] OP_STR  = OPW'(2);
    localparam logic [OPW-1:0] OP_SWP  = OPW'(3);
    localparam logic [OPW-1:0] OP_BRA  = OPW'(4);
    localparam logic [OPW-1:0] OP_BRR  = OPW'(5);
    localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
    localparam logic [OPW-1:0] OP_BNR  = OPW'(7);
    localparam logic [OPW-1:0] OP_ALU  = OPW'(8);
    localparam logic [OPW-1:0] OP_HLT  = OPW'(15);

    localparam logic [ALUW-1:0] ALU_RR   = ALUW'(0);
    localparam logic [ALUW-1:0] ALU_RI   = ALUW'(1);
    localparam logic [ALUW-1:0] ALU_PASS = ALUW'(2);

    localparam logic [MMW-1:0] MM_IMM    = MMW'(AM_IMM);
    localparam logic [7:0]     WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       bus_err_q, bus_err_d;
    logic       ill_op_q, ill_op_d;

    logic op_valid;
    logic br_hit;
    logic mem_stall;
    logic timeout;

    // Memory handshake: mem_req is held until mem_rdy; a request that has been
    // refused WAIT_MAX consecutive cycles aborts to HALT unless mem_rdy rescues it.
    assign op_valid  = (opcode <= OP_ALU) || (opcode == OP_HLT);
    assign br_hit    = (stat & mm) != '0;
    assign mem_stall = mem_req && !mem_rdy;
    assign timeout   = mem_stall && (wait_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= START1;
            wait_q    <= '0;
            bus_err_q <= 1'b0;
            ill_op_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bus_err_q <= bus_err_d;
            ill_op_q  <= ill_op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bus_err_d = bus_err_q;
        ill_op_d  = ill_op_q;
        case (state_q)
            START1:  state_d = FETCH;
            FETCH:   if (mem_rdy) state_d = DECODE;
            DECODE: begin
                if (!op_valid) ill_op_d = 1'b1;
                state_d = (opcode == OP_HLT) ? HALT : EXECUTE;
            end
            EXECUTE: begin
                if (opcode == OP_LOD || opcode == OP_STR)      state_d = MEM;
                else if (opcode == OP_ALU || opcode == OP_SWP) state_d = WB;
                else                                           state_d = FETCH;
            end
            MEM:     if (mem_rdy) state_d = (opcode == OP_LOD) ? WB : FETCH;
            WB:      state_d = (opcode == OP_SWP) ? WB2 : FETCH;
            WB2:     state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = START1;
        endcase
        if (timeout) begin
            bus_err_d = 1'b1;
            state_d   = HALT;
        end
        wait_d = (mem_stall && state_d == state_q) ? wait_q + 8'd1 : 8'd0;
    end

    always_comb begin
        rf_we    = 1'b0;
        alu_op   = ALU_PASS;
        wb_sel   = 1'b0;
        rb_sel   = 1'b0;
        ir_load  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        halted   = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_rdy) begin
                    ir_load  = 1'b1;
                    pc_write = 1'b1;
                end
            end
            EXECUTE: begin
                case (opcode)
                    OP_ALU: alu_op = (mm == MM_IMM) ? ALU_RI : ALU_RR;
                    OP_BRA, OP_BRR: begin
                        if (br_hit) begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                            br_sel   = (opcode == OP_BRR);
                        end
                    end
                    OP_BNE, OP_BNR: begin
                        if (!br_hit) begin
                            pc_write = 1'b1;
                            pc_sel   = 1'b1;
                            br_sel   = (opcode == OP_BNR);
                        end
                    end
                    default: alu_op = ALU_PASS;
                endcase
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STR);
            end
            WB: begin
                rf_we  = 1'b1;
                wb_sel = (opcode == OP_LOD);
            end
            WB2: begin
                rf_we  = 1'b1;
                rb_sel = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    assign bus_err = bus_err_q;
    assign ill_op  = ill_op_q;
    assign state_o = state_q;

    // OP_NOOP documents the encoding; it simply falls through as "no action".
    logic unused_noop;
    assign unused_noop = (opcode == OP_NOOP);

endmodule
